// File: rtl/rbot_moves_pkg.sv
// rbot_moves_pkg: move codes, batch geometry and move-legality helpers shared by the packer and the cube-state updater
package rbot_moves_pkg;
  localparam int MOVE_W = 4;
  localparam int MAX_MOVES = 50;
  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] R   = 4'd2;
  localparam logic [3:0] Ri  = 4'd3;
  localparam logic [3:0] U   = 4'd4;
  localparam logic [3:0] Ui  = 4'd5;
  localparam logic [3:0] F   = 4'd6;
  localparam logic [3:0] Fi  = 4'd7;
  localparam logic [3:0] L   = 4'd8;
  localparam logic [3:0] Li  = 4'd9;
  localparam logic [3:0] B   = 4'd10;
  localparam logic [3:0] Bi  = 4'd11;
  localparam logic [3:0] D   = 4'd12;
  localparam logic [3:0] Di  = 4'd13;
  typedef enum logic [1:0] {FILL, SEND, WAIT} pack_state_t;
  function automatic logic is_legal_move(input logic [3:0] m);
    return m >= 4'd2 && m <= 4'd13;
  endfunction
  function automatic logic is_inverse(input logic [3:0] a, input logic [3:0] b);
    return is_legal_move(a) && is_legal_move(b) && (a ^ b) == 4'd1;
  endfunction
endpackage

// File: rtl/move_batch_packer.sv
// move_batch_packer: packs 4-bit move codes MSB-first into a 50-slot NOP-padded batch for the cube-state updater
// Ports: clock, reset_n (async active-low); move_in/move_valid/move_ready accept handshake; flush sends a partial batch;
//   moves/new_moves_ready/move_count present a batch held until state_updated; busy while sent or awaiting; bad_move sticky.
// Option MOVE_CANCEL_EN: a move that inverts the last packed move clears that slot instead of being appended.
module move_batch_packer
  import rbot_moves_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [MOVE_W-1:0]           move_in,
  input  logic                        move_valid,
  output logic                        move_ready,
  input  logic                        flush,
  output logic [MAX_MOVES*MOVE_W-1:0] moves,
  output logic                        new_moves_ready,
  input  logic                        state_updated,
  output logic [5:0]                  move_count,
  output logic                        busy,
  output logic                        bad_move
);
  localparam int BW = MAX_MOVES*MOVE_W;
  localparam logic [5:0] FULL = 6'(MAX_MOVES);
  pack_state_t state, state_n;
  logic [BW-1:0] moves_n;
  logic [5:0] count_n, last;
  logic ready_q, bad_n, accept, legal, cancel;
  assign move_ready = ready_q;
  assign new_moves_ready = state == SEND;
  assign busy = state != FILL;
  assign accept = move_valid & ready_q;
  assign legal = is_legal_move(move_in);
  assign last = move_count - 6'd1;
`ifdef MOVE_CANCEL_EN
  logic [BW-1:0] prev_sh;
  assign prev_sh = moves << {last, 2'b00};
  assign cancel = accept & (move_count != 6'd0) & is_inverse(move_in, prev_sh[BW-1 -: MOVE_W]);
`else
  assign cancel = 1'b0;
`endif
  always_comb begin
    state_n = state;
    moves_n = moves;
    count_n = move_count;
    bad_n = bad_move | (accept & move_in != NOP & !legal);
    if (state == FILL) begin
      // slots past move_count are always zero, so an OR places the new code
      if (cancel) begin
        moves_n = moves & ~({4'hF, {(BW-MOVE_W){1'b0}}} >> {last, 2'b00});
        count_n = last;
      end else if (accept & legal) begin
        moves_n = moves | ({move_in, {(BW-MOVE_W){1'b0}}} >> {move_count, 2'b00});
        count_n = move_count + 6'd1;
      end
      state_n = (count_n == FULL || (flush && count_n != 6'd0)) ? SEND : FILL;
    end else if (state == SEND) begin
      state_n = WAIT;
    end else if (state_updated) begin
      state_n = FILL;
      moves_n = '0;
      count_n = '0;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= FILL;
      moves <= '0;
      move_count <= '0;
      bad_move <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      moves <= moves_n;
      move_count <= count_n;
      bad_move <= bad_n;
      ready_q <= state_n == FILL;
    end
endmodule

// File: tb/tb_move_batch_packer.sv
// tb_move_batch_packer: directed self-checking bench for move_batch_packer
module tb_move_batch_packer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] move_in = 4'd0;
  logic move_valid = 1'b0;
  logic move_ready;
  logic flush = 1'b0;
  logic [199:0] moves;
  logic new_moves_ready;
  logic state_updated = 1'b0;
  logic [5:0] move_count;
  logic busy;
  logic bad_move;
  int checks = 0;
  int errors = 0;
  move_batch_packer dut (
    .clock(clock), .reset_n(reset_n), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .flush(flush), .moves(moves), .new_moves_ready(new_moves_ready),
    .state_updated(state_updated), .move_count(move_count), .busy(busy), .bad_move(bad_move)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic push(input logic [3:0] code);
    move_in = code;
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
  endtask
  initial begin
    logic [199:0] all_r;
    all_r = {50{4'h2}};
    tick();
    chk("rst_moves", moves, 0);
    chk("rst_nmr", new_moves_ready, 0);
    chk("rst_count", move_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bad", bad_move, 0);
    chk("rst_ready", move_ready, 0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", move_ready, 1);
    // 50 back-to-back R
    move_in = 4'd2;
    move_valid = 1'b1;
    for (int i = 0; i < 49; i++) begin
      tick();
      chk("full_no_strobe_early", new_moves_ready, 0);
    end
    chk("full_count49", move_count, 49);
    tick();
    move_valid = 1'b0;
    chk("full_strobe", new_moves_ready, 1);
    chk("full_count", move_count, 50);
    chk("full_moves", moves, all_r);
    chk("full_ready", move_ready, 0);
    chk("full_busy", busy, 1);
    tick();
    chk("full_strobe_once", new_moves_ready, 0);
    tick();
    tick();
    chk("full_wait_ready", move_ready, 0);
    chk("full_wait_moves", moves, all_r);
    state_updated = 1'b1;
    tick();
    state_updated = 1'b0;
    chk("full_upd_ready", move_ready, 1);
    chk("full_upd_moves", moves, 0);
    chk("full_upd_count", move_count, 0);
    chk("full_upd_busy", busy, 0);
    // U,F,D then flush
    push(4'd4);
    push(4'd6);
    push(4'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ufd_strobe", new_moves_ready, 1);
    chk("ufd_moves", moves, {12'h46C, 188'd0});
    chk("ufd_count", move_count, 3);
    tick();
    chk("ufd_strobe_once", new_moves_ready, 0);
    tick();
    tick();
    tick();
    tick();
    chk("ufd_wait_moves", moves, {12'h46C, 188'd0});
    state_updated = 1'b1;
    tick();
    state_updated = 1'b0;
    chk("ufd_upd_moves", moves, 0);
    chk("ufd_upd_ready", move_ready, 1);
    // state_updated in FILL is ignored
    state_updated = 1'b1;
    tick();
    state_updated = 1'b0;
    chk("upd_in_fill_busy", busy, 0);
    // illegal code then flush with empty batch
    push(4'd15);
    chk("bad_set", bad_move, 1);
    chk("bad_count", move_count, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_nmr", new_moves_ready, 0);
    chk("empty_flush_busy", busy, 0);
    push(4'd0);
    chk("nop_count", move_count, 0);
    chk("bad_sticky", bad_move, 1);
    // move and flush together at count 2
    push(4'd2);
    push(4'd4);
    move_in = 4'd8;
    move_valid = 1'b1;
    flush = 1'b1;
    tick();
    move_valid = 1'b0;
    flush = 1'b0;
    chk("mvflush_strobe", new_moves_ready, 1);
    chk("mvflush_count", move_count, 3);
    chk("mvflush_moves", moves, {12'h248, 188'd0});
    tick();
    chk("mvflush_wait_busy", busy, 1);
    // async reset during WAIT
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_nmr", new_moves_ready, 0);
    chk("arst_moves", moves, 0);
    chk("arst_count", move_count, 0);
    chk("arst_bad", bad_move, 0);
    chk("arst_ready", move_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst_ready_back", move_ready, 1);
    // R,U,Ui,B then flush
    push(4'd2);
    state_updated = 1'b1;
    tick();
    state_updated = 1'b0;
    chk("upd_fill_count", move_count, 1);
    push(4'd4);
    push(4'd5);
    push(4'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cancel_strobe", new_moves_ready, 1);
`ifdef MOVE_CANCEL_EN
    chk("cancel_count", move_count, 2);
    chk("cancel_moves", moves, {8'h2A, 192'd0});
`else
    chk("cancel_count", move_count, 4);
    chk("cancel_moves", moves, {16'h245A, 184'd0});
`endif
    tick();
    state_updated = 1'b1;
    tick();
    state_updated = 1'b0;
    chk("final_moves", moves, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_batch_packer.md
Name: move_batch_packer

Overview:
- Producer side of the 200-bit move-batch interface consumed by the cube-state updater.
- Accepts single 4-bit move codes from the solver or sequencer through a valid/ready handshake.
- Packs them MSB-first into a 50-slot batch and pads unused slots with NOP.
- Pulses new_moves_ready, then holds the batch stable until the updater returns state_updated.

Parameters:
- MAX_MOVES, 50, slots per batch.
- MOVE_W, 4, bits per move code. moves width = MAX_MOVES*MOVE_W = 200.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- move_in  in  4  move code: 0=NOP, 2=R, 3=Ri, 4=U, 5=Ui, 6=F, 7=Fi, 8=L, 9=Li, 10=B, 11=Bi, 12=D, 13=Di.
- move_valid  in  1  move_in is valid this cycle.
- move_ready  out  1  block can accept a move this cycle.
- flush  in  1  send the partial batch now.
- moves  out  200  packed batch; slot k occupies bits [199-4k : 196-4k].
- new_moves_ready  out  1  one-cycle strobe: batch valid.
- state_updated  in  1  updater finished applying the batch.
- move_count  out  6  slots filled in the current batch (0..50).
- busy  out  1  a batch is sent or awaiting state_updated.
- bad_move  out  1  sticky; set when an illegal code is offered.

Behaviour:
- Reset values: moves=0, new_moves_ready=0, move_count=0, busy=0, bad_move=0, state=FILL. move_ready goes to 1 on the first clock after reset deasserts.
- States:
  - FILL: move_ready=1.
  - SEND: one cycle; new_moves_ready=1, busy=1.
  - WAIT: busy=1, move_ready=0.
- Accept: a move is accepted on a clock edge with move_valid & move_ready.
  - Legal codes 2..13 are written to slot move_count; move_count increments.
  - Code 0 is accepted and discarded; the count is unchanged.
  - Codes 1, 14, 15 are accepted and discarded, and bad_move is set. bad_move clears only on reset.
- FILL -> SEND when either:
  - an accept brings move_count to MAX_MOVES (same edge), or
  - flush=1 with move_count>0 after any same-cycle accept.
- Flush with move_count==0, including after a same-cycle NOP or illegal accept, is ignored and the state stays FILL.
- Simultaneous move_valid and flush: the move is packed first and is included in the flushed batch.
- SEND -> WAIT unconditionally after one cycle. new_moves_ready is high for exactly one cycle per batch.
- moves and move_count are stable from SEND entry until WAIT exit, because the updater reads moves after the strobe.
- WAIT -> FILL on state_updated=1. On that edge moves clears to 0 (all NOP) and move_count clears to 0. move_ready is 1 the following cycle.
- state_updated outside WAIT is ignored.
- Latency: final accept -> new_moves_ready is 1 cycle. state_updated -> move_ready is 1 cycle.
- Reset mid-batch (any state): the batch is discarded, all outputs return to reset values, and no strobe is emitted.
- Unused trailing slots are always 0. The updater treats them as no-ops.

Optional Feature:
- Macro: MOVE_CANCEL_EN.
- Defined: in FILL, a legal move whose code differs from slot move_count-1 only in bit 0 (its inverse) is not appended. Instead that slot is cleared to 0 and move_count decrements.
  - Cancelling can empty the batch. A flush on that same edge is then ignored.
  - Example: R,Ri -> move_count=0.
  - Example: R,U,Ui -> move_count=1, slot 0=R.
- Not defined: every legal move is appended, with no cancellation.

Decomposition:
- Shared package rbot_moves_pkg holds:
  - move code localparams (NOP, R..Di);
  - MOVE_W, MAX_MOVES;
  - is_legal_move and is_inverse functions, which the updater also uses.
- No sub-module; packer state machine and slot write are a single module.

Test Plan:
- 50 accepts of R (code 2) back-to-back -> new_moves_ready pulses the cycle after the 50th accept, moves = 200'h2222...2, move_count=50, move_ready=0 until state_updated.
- Accept U,F,D then flush -> moves[199:188]=12'h46C, moves[187:0]=0, move_count=3, one strobe. state_updated 5 cycles later -> moves=0 and move_ready=1 next cycle.
- Offer code 15, then flush -> bad_move=1 sticky, move_count=0, no strobe.
- move_valid (L=8) and flush in the same cycle at move_count=2 -> strobe with move_count=3, slot 2=8.
- Assert reset_n=0 during WAIT -> busy, new_moves_ready, moves, move_count all 0 immediately, with no clock needed.
- With MOVE_CANCEL_EN: R,U,Ui,B then flush -> move_count=2, moves[199:192]=8'h2A. Without the macro -> move_count=4, moves[199:184]=16'h245A.
